wing_port_sequencer: RTL
========================

WING_PORT_SEQUENCER -- requirements
Module: wing_port_sequencer

Interface
REQ-001 Parameter TURN_CYCLES, default 2: bus-turnaround wait after any DIR change; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 1: cycles a written byte is guaranteed driven before the next command is accepted; legal range 1..15.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk in 1 (all logic on rising edge); rst in 1 (synchronous, active-high).
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out 1  command accepted when cmd_valid and cmd_ready are both high on the same edge.
REQ-006 cmd_write  in  1  1 = write byte to pins, 0 = read byte from pins.
REQ-007 cmd_data  in  8  write byte; ignored for reads.
REQ-008 rsp_valid  out 1  read result available.
REQ-009 rsp_ready  in  1  result consumed when rsp_valid and rsp_ready are both high on the same edge.
REQ-010 rsp_data  out 8  read result.
REQ-011 DIR  out 1  to wing driver DIRx; 1 = port drives pins, 0 = port listens.
REQ-012 OUT  out 8  to wing driver INx; byte driven when DIR=1.
REQ-013 IN  in  8  from wing driver OUTx; pin value when DIR=0.
REQ-014 busy  out 1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, TURN, DRIVE, SAMPLE and RESP; cmd_ready SHALL equal (state==IDLE).
REQ-016 On accept of a write, OUT SHALL load cmd_data on that edge; on accept of a read, OUT SHALL hold its value.
REQ-017 On accept, if the required direction (write=1, read=0) differs from DIR, DIR SHALL take the new value on that edge and the FSM SHALL enter TURN for exactly TURN_CYCLES cycles.
REQ-018 If the direction already matches, the FSM SHALL skip TURN entirely.
REQ-019 After TURN or direct accept, a write SHALL enter DRIVE for exactly HOLD_CYCLES cycles and then return to IDLE; writes SHALL produce no response.
REQ-020 After TURN or direct accept, a read SHALL spend one cycle in SAMPLE and SHALL capture IN into rsp_data on the SAMPLE-to-RESP edge.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_data stable until rsp_ready; on handshake the FSM SHALL enter IDLE and rsp_valid SHALL drop on that edge.
REQ-022 Latency, with accept at edge T:
  - write without turn: cmd_ready high again at cycle T+HOLD_CYCLES+1;
  - write with turn: cmd_ready high again at T+TURN_CYCLES+HOLD_CYCLES+1;
  - read without turn: rsp_valid high at T+2, data = IN during cycle T+1;
  - read with turn: rsp_valid high at T+TURN_CYCLES+2.
REQ-023 DIR and OUT SHALL change only on an accept edge; they SHALL hold through consecutive same-direction commands, with no glitch on back-to-back writes.
REQ-024 The turn/hold counter SHALL be 4 bits, load (N-1) on state entry and exit at 0; it SHALL never wrap.
REQ-025 The block SHALL ignore cmd_valid outside IDLE and rsp_ready outside RESP, with no state change.
REQ-026 If rsp_ready is held high before RESP, the handshake SHALL complete on the first RESP cycle, so RESP lasts one cycle.

Reset
REQ-027 While rst is high at an edge, from any state, the block SHALL produce: state=IDLE, DIR=0, OUT=8'h00, rsp_valid=0, rsp_data=8'h00, counter=0, busy=0.
REQ-028 rst SHALL take precedence over a simultaneous accept or response handshake; an in-flight command SHALL be dropped without a response.
REQ-029 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 After reset, write 8'hA5 (TURN=2, HOLD=1): DIR=1 and OUT=A5 at T+1; cmd_ready low for cycles T+1..T+3; cmd_ready high at T+4.
REQ-031 Two back-to-back writes (8'h01, 8'h02) with DIR already 1: no TURN; OUT=01 then 02; DIR stays 1 throughout; the second accept occurs at T+2.
REQ-032 After a write, read with IN=8'h3C: DIR=0 at T+1; rsp_valid at T+4 with rsp_data=3C; with rsp_ready low, rsp_valid and rsp_data hold for 5 cycles; the response completes when rsp_ready rises.
REQ-033 Read with DIR already 0 and rsp_ready tied high: rsp_valid pulses exactly 1 cycle at T+2; cmd_ready returns at T+3.
REQ-034 rst asserted during TURN of a read: next edge gives DIR=0, OUT=00, busy=0; rsp_valid never asserts.
REQ-035 cmd_valid held high during DRIVE with changing cmd_data: only the value present on each IDLE accept edge is loaded into OUT.

Source files
------------

// File: rtl/wing_port_sequencer.sv
// Byte-wide wing port sequencer: turns the pin driver around on direction
// changes, holds written bytes for a fixed time and returns sampled reads.
module wing_port_sequencer #(
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       DIR,
  output logic [7:0] OUT,
  input  logic [7:0] IN,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, TURN, DRIVE, SAMPLE, RESP} state_t;

  localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       op_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      DIR      <= 1'b0;
      OUT      <= 8'h00;
      rsp_data <= 8'h00;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_wr <= cmd_write;
          if (cmd_write) OUT <= cmd_data;
          // Direction flips on the accept edge so the driver starts turning now
          if (cmd_write != DIR) begin
            DIR   <= cmd_write;
            state <= TURN;
            cnt   <= TURN_LD;
          end else if (cmd_write) begin
            state <= DRIVE;
            cnt   <= HOLD_LD;
          end else begin
            state <= SAMPLE;
          end
        end
        TURN: begin
          if (cnt == 4'd0) begin
            if (op_wr) begin
              state <= DRIVE;
              cnt   <= HOLD_LD;
            end else begin
              state <= SAMPLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        SAMPLE: begin
          rsp_data <= IN;
          state    <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

endmodule
